hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: TIMEOUT, 64, max WAIT cycles before abort.
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  request a divide; sampled only in IDLE.
REQ-006 Port: is_signed  in  1  signed (1) / unsigned (0) divide; sampled with start.
REQ-007 Port: op_a  in  WIDTH  dividend; sampled with start.
REQ-008 Port: op_b  in  WIDTH  divisor; sampled with start.
REQ-009 Port: mthi  in  1  write wdata to hi; honoured only in IDLE.
REQ-010 Port: mtlo  in  1  write wdata to lo; honoured only in IDLE.
REQ-011 Port: wdata  in  WIDTH  data for mthi/mtlo.
REQ-012 Port: dv_load  out  1  one-cycle pulse loading the downstream unsigned divider core.
REQ-013 Port: dv_dividend  out  WIDTH  magnitude of captured dividend.
REQ-014 Port: dv_divisor  out  WIDTH  magnitude of captured divisor.
REQ-015 Port: dv_ready  in  1  divider core idle/result valid.
REQ-016 Port: dv_q, dv_r  in  WIDTH each  unsigned quotient/remainder from core.
REQ-017 Port: hi, lo  out  WIDTH each  architectural remainder/quotient registers.
REQ-018 Port: busy  out  1  high whenever state != IDLE.
REQ-019 Port: dbz  out  1  one-cycle pulse: divide by zero.
REQ-020 Port: tmo  out  1  one-cycle pulse: core timeout.

Function
REQ-021 FSM states: IDLE, LOAD, WAIT, FIX; decoded combinationally into busy.
REQ-022 IDLE + start + op_b!=0: capture operands/is_signed, -> LOAD.
REQ-023 IDLE + start + op_b==0: no core access; next edge lo=all-ones, hi=op_a, dbz=1 for one cycle, stay IDLE.
REQ-024 LOAD: dv_load=1 for exactly one cycle; dv_dividend/dv_divisor held stable from LOAD until exit of WAIT; -> WAIT.
REQ-025 WAIT: dv_ready ignored on first WAIT cycle (core-start guard); thereafter dv_ready=1 -> FIX, latching dv_q/dv_r.
REQ-026 WAIT counter counts WAIT cycles; reaching TIMEOUT -> IDLE, tmo=1 one cycle, hi/lo unchanged.
REQ-027 FIX: apply sign correction, write lo=quotient, hi=remainder at the FIX->IDLE edge; busy falls same edge.
REQ-028 Magnitudes: if is_signed and operand MSB=1, drive two's-complement negation; else raw value.
REQ-029 Signed quotient negated iff op_a and op_b signs differ; remainder negated iff op_a negative; unsigned: no correction.
REQ-030 Overflow case most-negative / -1 (signed): lo=most-negative (e.g. 0x80000000), hi=0, no flag.
REQ-031 Latency (nonzero divisor): start edge N -> LOAD cycle N+1 -> result in hi/lo at edge after core ready; busy high throughout.
REQ-032 start while busy: ignored, no queuing.
REQ-033 mthi/mtlo while busy: ignored; hi/lo untouched.
REQ-034 start together with mthi/mtlo in IDLE: start wins, writes ignored.
REQ-035 mthi and mtlo same cycle in IDLE: both registers written with wdata.
REQ-036 dv_dividend/dv_divisor are registered outputs; no combinational path from op_a/op_b.

Reset
REQ-037 reset=1 asynchronously forces IDLE; hi=0, lo=0, dv_load=0, dv_dividend=0, dv_divisor=0, busy=0, dbz=0, tmo=0, WAIT counter=0.
REQ-038 reset mid-operation (LOAD/WAIT/FIX) abandons the divide; no hi/lo update after reset release; first start after release behaves normally.

Verification
REQ-039 Unsigned: op_a=100, op_b=7, is_signed=0 -> one dv_load pulse, dv_dividend=100, dv_divisor=7; core returns 14/2 -> lo=14, hi=2, busy drops same edge.
REQ-040 Signed: op_a=-100 (0xFFFFFF9C), op_b=7 -> dv_dividend=100; core 14/2 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
REQ-041 Zero divisor: op_a=0x1234, op_b=0 -> no dv_load, dbz pulse, lo=0xFFFFFFFF, hi=0x1234, busy never asserts.
REQ-042 Timeout: hold dv_ready=0 after load -> tmo pulse after 64 WAIT cycles, IDLE, hi/lo retain prior values.
REQ-043 Interlock: mthi wdata=0xA5A5A5A5 during WAIT -> hi unchanged; same in IDLE -> hi=0xA5A5A5A5; start+mtlo same IDLE cycle -> lo gets quotient only.
REQ-044 Reset asserted in WAIT -> immediate IDLE, all outputs 0, later dv_ready=1 causes no hi/lo write.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// HI/LO divide sequencer: wraps an unsigned multi-cycle divider core with signed
// operand conditioning, divide-by-zero bypass, core timeout, and mthi/mtlo writes.
module hilo_div_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             dv_load,
  output logic [WIDTH-1:0] dv_dividend,
  output logic [WIDTH-1:0] dv_divisor,
  input  logic             dv_ready,
  input  logic [WIDTH-1:0] dv_q,
  input  logic [WIDTH-1:0] dv_r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             dbz,
  output logic             tmo
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FIX} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_dividend, r_divisor;
  logic [WIDTH-1:0] r_q, r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r;
  logic             r_load, r_dbz, r_tmo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_load     <= 1'b0;
      r_dbz      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_dbz  <= 1'b0;
      r_tmo  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op_b == '0) begin
              r_lo  <= '1;
              r_hi  <= op_a;
              r_dbz <= 1'b1;
            end else begin
              r_dividend <= mag(op_a, is_signed);
              r_divisor  <= mag(op_b, is_signed);
              r_neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              r_neg_r    <= is_signed & op_a[WIDTH-1];
              r_load     <= 1'b1;
              r_state    <= S_LOAD;
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The core may still show a stale ready on the first WAIT cycle.
          if (r_cnt != '0 && dv_ready) begin
            r_q     <= dv_q;
            r_r     <= dv_r;
            r_state <= S_FIX;
          end else if (r_cnt == CNT_LAST) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_FIX: begin
          r_lo    <= cond_neg(r_q, r_neg_q);
          r_hi    <= cond_neg(r_r, r_neg_r);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign dv_load     = r_load;
  assign dv_dividend = r_dividend;
  assign dv_divisor  = r_divisor;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign dbz         = r_dbz;
  assign tmo         = r_tmo;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: behavioural divider core plus an expected-result queue.
module tb_hilo_div_ctrl;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, is_signed = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, wdata = '0;
  logic         dv_load, busy, dbz, tmo;
  logic [W-1:0] dv_dividend, dv_divisor, hi, lo;
  logic         dv_ready = 1'b1;
  logic [W-1:0] dv_q = '0, dv_r = '0;

  int checks = 0;
  int errors = 0;
  int loads = 0;
  int core_lat = 1;
  bit core_hang = 1'b0;
  int core_cnt = 0;
  logic [W-1:0] pend_q = '0, pend_r = '0;
  logic [2*W-1:0] exp_q[$];

  hilo_div_ctrl #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .dv_load(dv_load), .dv_dividend(dv_dividend), .dv_divisor(dv_divisor),
    .dv_ready(dv_ready), .dv_q(dv_q), .dv_r(dv_r),
    .hi(hi), .lo(lo), .busy(busy), .dbz(dbz), .tmo(tmo)
  );

  always #5 clk = ~clk;

  // Unsigned core: ready stays at its old value for the cycle after load.
  always @(posedge clk) begin
    if (dv_load === 1'b1) begin
      loads++;
      pend_q   <= (dv_divisor == '0) ? '1 : dv_dividend / dv_divisor;
      pend_r   <= (dv_divisor == '0) ? '1 : dv_dividend % dv_divisor;
      core_cnt <= core_lat;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_hang) begin
        dv_ready <= 1'b1;
        dv_q     <= pend_q;
        dv_r     <= pend_r;
      end else begin
        dv_ready <= 1'b0;
      end
    end
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [W-1:0] sa, sb, sq, sr;
    if (b == '0) return {a, {W{1'b1}}};
    if (!s) return {a % b, a / b};
    if (a == MINV && b == '1) return {{W{1'b0}}, MINV};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit push);
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    if (push) exp_q.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({busy, dv_load, dbz, tmo} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {busy, dv_load, dbz, tmo}); end
    checks++; if ({hi, lo} !== '0) begin errors++;
      $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    checks++; if ({dv_dividend, dv_divisor} !== '0) begin errors++;
      $display("FAIL reset_dv: got %h want 0", {dv_dividend, dv_divisor}); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_unsigned;
    int l0;
    bit to;
    logic [2*W-1:0] e;
    l0 = loads;
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    checks++; if ({dv_load, busy} !== 2'b11) begin errors++;
      $display("FAIL unsigned_load: got %b want 11", {dv_load, busy}); end
    checks++; if ({dv_dividend, dv_divisor} !== {32'd100, 32'd7}) begin errors++;
      $display("FAIL unsigned_dv: got %h want %h", {dv_dividend, dv_divisor}, {32'd100, 32'd7}); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL unsigned_timeout: got busy want idle"); end
    e = exp_q.pop_front();
    checks++; if ({hi, lo} !== e || e !== {32'd2, 32'd14}) begin errors++;
      $display("FAIL unsigned_result: got %h want %h", {hi, lo}, e); end
    checks++; if (loads - l0 !== 1) begin errors++;
      $display("FAIL unsigned_loadcount: got %0d want 1", loads - l0); end
  endtask

  task automatic test_signed;
    logic [W-1:0] ta[7] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd7, MINV, MINV, 32'hFFFF_FFFF};
    logic [W-1:0] tb[7] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'd1, 32'd2};
    bit to;
    logic [2*W-1:0] e;
    logic [W-1:0] ma, mb;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], 1'b1, 1'b1);
      ma = ta[i][W-1] ? (~ta[i] + 32'd1) : ta[i];
      mb = tb[i][W-1] ? (~tb[i] + 32'd1) : tb[i];
      checks++; if ({dv_dividend, dv_divisor} !== {ma, mb}) begin errors++;
        $display("FAIL signed_mag[%0d]: got %h want %h", i, {dv_dividend, dv_divisor}, {ma, mb}); end
      wait_idle(to);
      e = exp_q.pop_front();
      checks++; if (to || {hi, lo} !== e) begin errors++;
        $display("FAIL signed_result[%0d]: got %h want %h", i, {hi, lo}, e); end
    end
  endtask

  task automatic test_dbz;
    int l0;
    l0 = loads;
    @(negedge clk);
    op_a = 32'h1234; op_b = '0; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({dbz, busy} !== 2'b10) begin errors++;
      $display("FAIL dbz_pulse: got %b want 10", {dbz, busy}); end
    checks++; if ({hi, lo} !== {32'h1234, 32'hFFFF_FFFF}) begin errors++;
      $display("FAIL dbz_result: got %h want %h", {hi, lo}, {32'h1234, 32'hFFFF_FFFF}); end
    @(negedge clk);
    checks++; if ({dbz, busy, dv_load} !== 3'b000) begin errors++;
      $display("FAIL dbz_after: got %b want 000", {dbz, busy, dv_load}); end
    checks++; if (loads !== l0) begin errors++;
      $display("FAIL dbz_noload: got %0d want %0d", loads, l0); end
  endtask

  task automatic test_timeout;
    int n;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'hCAFE_F00D}}) begin errors++;
      $display("FAIL mthi_mtlo_both: got %h want %h", {hi, lo}, {2{32'hCAFE_F00D}}); end
    core_hang = 1'b1;
    issue(32'd50, 32'd5, 1'b0, 1'b0);
    n = 1;
    while (tmo !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 66) begin errors++;
      $display("FAIL tmo_latency: got %0d cycles want 66", n); end
    checks++; if (busy !== 1'b0 || {hi, lo} !== {2{32'hCAFE_F00D}}) begin errors++;
      $display("FAIL tmo_state: got busy=%b hilo=%h want 0 %h", busy, {hi, lo}, {2{32'hCAFE_F00D}}); end
    @(negedge clk);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b want 0", tmo); end
    core_hang = 1'b0;
  endtask

  task automatic test_interlock;
    int l0;
    bit to;
    logic [W-1:0] h0;
    logic [2*W-1:0] e;
    core_lat = 6;
    l0 = loads;
    h0 = hi;
    issue(32'd1000, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    start = 1'b1; op_a = 32'd77; op_b = 32'd11;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    checks++; if (hi !== h0) begin errors++;
      $display("FAIL mthi_busy: got %h want %h", hi, h0); end
    checks++; if (dv_dividend !== 32'd1000 || dv_divisor !== 32'd3) begin errors++;
      $display("FAIL dv_stable: got %h/%h want 3e8/3", dv_dividend, dv_divisor); end
    wait_idle(to);
    e = exp_q.pop_front();
    checks++; if (to || {hi, lo} !== e) begin errors++;
      $display("FAIL busy_start_ignored: got %h want %h", {hi, lo}, e); end
    checks++; if (loads - l0 !== 1) begin errors++;
      $display("FAIL busy_loadcount: got %0d want 1", loads - l0); end
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    checks++; if (hi !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL mthi_idle: got %h want a5a5a5a5", hi); end
    @(negedge clk);
    op_a = 32'd1000; op_b = 32'd3; is_signed = 1'b0; start = 1'b1;
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    checks++; if (lo === 32'hDEAD_BEEF) begin errors++;
      $display("FAIL start_mtlo_write: got %h want not deadbeef", lo); end
    wait_idle(to);
    e = exp_q.pop_front();
    checks++; if (to || {hi, lo} !== e) begin errors++;
      $display("FAIL start_mtlo_result: got %h want %h", {hi, lo}, e); end
    core_lat = 1;
  endtask

  task automatic test_reset_mid;
    bit to;
    logic [2*W-1:0] e;
    core_lat = 4;
    issue(32'd500, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, dv_load, dbz, tmo} !== 4'b0) begin errors++;
      $display("FAIL midreset_ctrl: got %b want 0000", {busy, dv_load, dbz, tmo}); end
    checks++; if ({hi, lo, dv_dividend, dv_divisor} !== '0) begin errors++;
      $display("FAIL midreset_data: got %h want 0", {hi, lo, dv_dividend, dv_divisor}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if ({hi, lo} !== '0 || busy !== 1'b0) begin errors++;
      $display("FAIL midreset_nowrite: got %h busy=%b want 0", {hi, lo}, busy); end
    issue(32'd500, 32'd5, 1'b0, 1'b1);
    wait_idle(to);
    e = exp_q.pop_front();
    checks++; if (to || {hi, lo} !== e) begin errors++;
      $display("FAIL midreset_recover: got %h want %h", {hi, lo}, e); end
    core_lat = 1;
  endtask

  task automatic test_back_to_back;
    bit to;
    logic [2*W-1:0] e;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      core_lat = $urandom_range(1, 4);
      issue(a, b, s, 1'b1);
      wait_idle(to);
      e = exp_q.pop_front();
      checks++; if (to || {hi, lo} !== e) begin errors++;
        $display("FAIL b2b[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, s, {hi, lo}, e); end
    end
    core_lat = 1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_dbz;
    test_timeout;
    test_interlock;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
